trunc: RTL
==========

# trunc

Operand narrowing stage, the inverse of the operand zero-extension unit. It accepts DATASIZE-bit datapath words over a valid/ready handshake and emits OPERANDSIZE-bit operand fields through a 2-entry buffer. It flags every word whose dropped upper bits are non-zero and keeps a saturating count of such words. It sits between the ALU/register-file result path and the immediate/operand fields written back toward instruction memory or narrow peripherals.

## Interface
- DATASIZE, 16, input word width
- OPERANDSIZE, 11, output field width; must satisfy OPERANDSIZE ≤ DATASIZE
- CNTSIZE, 8, overflow counter width
- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  reset, asynchronous, active-low
- datain_i  input  DATASIZE  word to narrow
- validin_i  input  1  datain_i valid
- readyin_o  output  1  buffer can accept a word
- dataout_o  output  OPERANDSIZE  narrowed field at buffer head
- ovf_o  output  1  head word had non-zero dropped bits; aligned with dataout_o
- validout_o  output  1  head entry valid
- readyout_i  input  1  consumer accepts head
- ovfcnt_o  output  CNTSIZE  saturating count of accepted overflowing words
- clrcnt_i  input  1  synchronous clear of ovfcnt_o

## Operation
- DIF = DATASIZE − OPERANDSIZE. Unsigned overflow = |datain_i[DATASIZE−1:OPERANDSIZE]|. If DIF = 0, overflow is constant 0 and data passes through unchanged.
- Push: validin_i & readyin_o. The narrowed field and overflow bit are computed at push and stored with the entry.
- Pop: validout_o & readyout_i. The head is removed and the next entry, if any, is presented.
- Buffer: 2 entries, in-order, with occupancy 0..2. readyin_o = (occupancy < 2). validout_o = (occupancy > 0). Both are decoded from registers only, with no combinational path from inputs.
- Push and pop in the same cycle leave occupancy unchanged. A push at occupancy 2 is impossible because readyin_o = 0. A pop at occupancy 0 is ignored.
- Counter: increments by 1 on each push whose overflow = 1. It holds at 2^CNTSIZE − 1 and does not wrap. If clrcnt_i is high, the counter goes to 0 and any increment in that cycle is dropped.
- Upstream must hold datain_i stable while validin_i is high and readyin_o is low. The block does not check this.

## Timing
- Reset values (asserted asynchronously, held while rst_n_i = 0):
  - dataout_o = 0, ovf_o = 0, validout_o = 0, ovfcnt_o = 0
  - readyin_o = 1
  - occupancy = 0
- Reset mid-operation flushes both entries immediately. No partial transfer completes.
- Latency: a word pushed at edge N appears on dataout_o/validout_o after edge N, in the same cycle the push completes registering.
- Throughput: 1 word per cycle sustained while readyout_i = 1.
- Backpressure: with readyout_i = 0, two pushes fill the buffer and readyin_o deasserts after the second push edge. readyin_o reasserts the cycle after the first pop.
- ovfcnt_o updates at the push edge, in the same edge the entry is written.

## Configuration
- TRUNC_SAT_EN defined:
  - An overflowing word stores dataout = all ones (2^OPERANDSIZE − 1) instead of the low bits.
  - ovf_o and the counter behave identically in both builds.
- TRUNC_SAT_EN undefined:
  - dataout = datain_i[OPERANDSIZE−1:0], plain truncation.

## Test plan
- Reset: hold rst_n_i = 0 with validin_i = 1 -> all outputs at reset values. Release -> first push of 16'h0123 gives dataout_o = 11'h123, ovf_o = 0, validout_o = 1 one edge later.
- Overflow: push 16'hF8AB -> ovf_o = 1, ovfcnt_o = 1. dataout_o = 11'h0AB without TRUNC_SAT_EN, 11'h7FF with it.
- Backpressure: readyout_i = 0, push 16'h0001 then 16'h0002 -> readyin_o = 0. A third word is held upstream. Raising readyout_i pops 11'h001 then 11'h002 in order, with no loss or duplication.
- Streaming: readyout_i = 1, push 100 consecutive words 0..99 -> 100 outputs in order, readyin_o never deasserts, occupancy ≤ 1.
- Counter: CNTSIZE = 2, push 5 overflowing words -> ovfcnt_o sticks at 3. Assert clrcnt_i together with an overflowing push -> ovfcnt_o = 0.
- Reset mid-flight: buffer full, assert rst_n_i = 0 -> validout_o = 0 and readyin_o = 1 immediately (asynchronous). Flushed entries never appear after release.

Source files
------------

// File: rtl/trunc.sv
// rtl/trunc.sv - narrows DATASIZE-bit words to OPERANDSIZE-bit fields through a 2-entry buffer.
// Optional build macro TRUNC_SAT_EN: overflowing words store all-ones instead of the low bits.
module trunc #(
  parameter int DATASIZE    = 16,
  parameter int OPERANDSIZE = 11,
  parameter int CNTSIZE     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [DATASIZE-1:0]    datain_i,
  input  logic                   validin_i,
  output logic                   readyin_o,
  output logic [OPERANDSIZE-1:0] dataout_o,
  output logic                   ovf_o,
  output logic                   validout_o,
  input  logic                   readyout_i,
  output logic [CNTSIZE-1:0]     ovfcnt_o,
  input  logic                   clrcnt_i
);

  logic [1:0][OPERANDSIZE-1:0] data_q, data_d;
  logic [1:0]                  ovf_q, ovf_d;
  logic                        wr_ptr_q, wr_ptr_d;
  logic                        rd_ptr_q, rd_ptr_d;
  logic [1:0]                  occ_q, occ_d;
  logic [CNTSIZE-1:0]          cnt_q, cnt_d;

  logic                   ovf_in;
  logic [OPERANDSIZE-1:0] field_in;
  logic                   push, pop;

  generate
    if (DATASIZE > OPERANDSIZE) begin : g_drop
      assign ovf_in = |datain_i[DATASIZE-1:OPERANDSIZE];
    end else begin : g_pass
      assign ovf_in = 1'b0;
    end
  endgenerate

`ifdef TRUNC_SAT_EN
  assign field_in = ovf_in ? '1 : datain_i[OPERANDSIZE-1:0];
`else
  assign field_in = datain_i[OPERANDSIZE-1:0];
`endif

  // Handshake outputs come straight from occupancy so neither side sees a combinational path.
  assign readyin_o  = (occ_q != 2'd2);
  assign validout_o = (occ_q != 2'd0);
  assign dataout_o  = data_q[rd_ptr_q];
  assign ovf_o      = ovf_q[rd_ptr_q];
  assign ovfcnt_o   = cnt_q;

  assign push = validin_i & readyin_o;
  assign pop  = validout_o & readyout_i;

  always_comb begin
    data_d   = data_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;

    if (push) begin
      data_d[wr_ptr_q] = field_in;
      ovf_d[wr_ptr_q]  = ovf_in;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    if (clrcnt_i) begin
      cnt_d = '0;
    end else if (push && ovf_in && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNTSIZE'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q   <= '0;
      ovf_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      cnt_q    <= '0;
    end else begin
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
